disp_pix_unpack: RTL and testbench

DISP_PIX_UNPACK -- requirements
Module: disp_pix_unpack

---
 rtl/disp_pix_unpack.sv | 204 ++++++++++++++++++++
 tb/tb_disp_pix_unpack.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_pix_unpack.sv
// disp_pix_unpack
// ---------------
// Display-side pixel unpacker. Selects between an idle blank screen, two
// pattern-generator modes (colour bars, grey "busy" screen) and a camera mode
// that unpacks RATIO pixels from each word of a first-word-fall-through FIFO.
// Camera mode first aligns to a start-of-frame word. It then shows one pixel
// per href cycle. On a FIFO underrun it fills the rest of the frame with
// FILL_PIX and realigns at the next vertical sync.
//
// Ports:
//   disp_clk, disp_rst        clock, asynchronous active-high reset
//   disp_bars/busy/cam        asynchronous mode requests (synchronized here)
//   fifo_empty, fifo_rd_data  FWFT FIFO head; bit RATIO*PIX_W = sof, +1 = eof
//   fifo_rd_en                pop the head word
//   href, vsync_n             sync generator timing (vsync_n active low)
//   pat_data                  pattern generator pixel
//   sync_en                   sync generator enable
//   pat_grey, pat_bars        pattern selects
//   data                      display pixel
//   underrun, underrun_cnt    one-cycle underrun pulse, saturating count

module disp_pix_unpack #(
  parameter int               PIX_W    = 16,
  parameter int               RATIO    = 2,   // 2 or 4
  parameter logic [PIX_W-1:0] FILL_PIX = '0,
  parameter int               CNT_W    = 8
) (
  input  logic                   disp_clk,
  input  logic                   disp_rst,
  input  logic                   disp_bars,
  input  logic                   disp_busy,
  input  logic                   disp_cam,
  input  logic                   fifo_empty,
  input  logic [RATIO*PIX_W+1:0] fifo_rd_data,
  output logic                   fifo_rd_en,
  input  logic                   href,
  input  logic                   vsync_n,
  input  logic [PIX_W-1:0]       pat_data,
  output logic                   sync_en,
  output logic                   pat_grey,
  output logic                   pat_bars,
  output logic [PIX_W-1:0]       data,
  output logic                   underrun,
  output logic [CNT_W-1:0]       underrun_cnt
);

  localparam int WORD_W = RATIO * PIX_W;
  localparam int LANE_W = $clog2(RATIO);

  typedef enum logic [5:0] {
    IDLE  = 6'b000001,
    BARS  = 6'b000010,
    BUSY  = 6'b000100,
    ALIGN = 6'b001000,
    CAM   = 6'b010000,
    FILL  = 6'b100000
  } state_t;

  state_t             state_reg, state_next;
  logic [LANE_W-1:0]  lane_reg, lane_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic               vsync_n_d1_reg;

  // Mode requests: bit 0 bars, bit 1 busy, bit 2 cam.
  logic [2:0] req_in;
  logic [2:0] req_sync;
  logic       bars_s, busy_s, cam_s;

  assign req_in = {disp_cam, disp_busy, disp_bars};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      logic s1_reg, s2_reg;
      always_ff @(posedge disp_clk or posedge disp_rst) begin
        if (disp_rst) begin
          s1_reg <= 1'b0;
          s2_reg <= 1'b0;
        end else begin
          s1_reg <= req_in[gi];
          s2_reg <= s1_reg;
        end
      end
      assign req_sync[gi] = s2_reg;
    end
  endgenerate

  assign bars_s = req_sync[0];
  assign busy_s = req_sync[1];
  assign cam_s  = req_sync[2];

  // Falling edge of vsync_n marks the frame boundary. The register resets
  // high so that a low vsync_n right after reset still counts as an edge.
  logic vs_fe;
  always_ff @(posedge disp_clk or posedge disp_rst) begin
    if (disp_rst) vsync_n_d1_reg <= 1'b1;
    else          vsync_n_d1_reg <= vsync_n;
  end
  assign vs_fe = !vsync_n && vsync_n_d1_reg;

  // Head-word fields. eof is deliberately ignored: only sof realigns frames.
  logic sof;
  logic unused_eof;
  assign sof        = fifo_rd_data[WORD_W];
  assign unused_eof = fifo_rd_data[WORD_W+1];

  // Pixel lanes of the head word, lane 0 in the least significant bits.
  logic [PIX_W-1:0] lane_arr [RATIO];
  generate
    for (gi = 0; gi < RATIO; gi++) begin : g_lane
      assign lane_arr[gi] = fifo_rd_data[gi*PIX_W +: PIX_W];
    end
  endgenerate

  logic last_lane;
  assign last_lane = (lane_reg == LANE_W'(RATIO - 1));

  always_ff @(posedge disp_clk or posedge disp_rst) begin
    if (disp_rst) begin
      state_reg <= IDLE;
      lane_reg  <= '0;
    end else begin
      state_reg <= state_next;
      lane_reg  <= lane_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    lane_next  = lane_reg;
    fifo_rd_en = 1'b0;
    sync_en    = 1'b0;
    pat_bars   = 1'b0;
    pat_grey   = 1'b0;
    data       = '0;
    underrun   = 1'b0;

    unique case (state_reg)
      IDLE: begin
        lane_next = '0;
        if (bars_s)      state_next = BARS;
        else if (busy_s) state_next = BUSY;
        else if (cam_s)  state_next = ALIGN;
      end

      BARS: begin
        sync_en  = 1'b1;
        pat_bars = 1'b1;
        data     = pat_data;
        if (!bars_s && vs_fe) state_next = IDLE;
      end

      BUSY: begin
        sync_en  = 1'b1;
        pat_grey = 1'b1;
        data     = pat_data;
        if (!busy_s && vs_fe) state_next = IDLE;
      end

      ALIGN: begin
        // Discard words until a start-of-frame word sits at the head; that
        // word is kept so CAM starts on its lane 0.
        sync_en    = 1'b1;
        lane_next  = '0;
        fifo_rd_en = !fifo_empty && !sof;
        if (!cam_s)                  state_next = IDLE;
        else if (!fifo_empty && sof) state_next = CAM;
      end

      CAM: begin
        sync_en = 1'b1;
        data    = lane_arr[lane_reg];
        if (href && !fifo_empty) begin
          lane_next  = last_lane ? '0 : lane_reg + 1'b1;
          fifo_rd_en = last_lane;
        end
        if (href && fifo_empty) data = FILL_PIX;
        // Leaving camera mode wins over an underrun in the same cycle.
        if (!cam_s && vs_fe) begin
          state_next = IDLE;
        end else if (href && fifo_empty) begin
          state_next = FILL;
          underrun   = 1'b1;
        end
      end

      FILL: begin
        sync_en = 1'b1;
        data    = FILL_PIX;
        if (vs_fe) state_next = cam_s ? ALIGN : IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge disp_clk or posedge disp_rst) begin
    if (disp_rst)                     cnt_reg <= '0;
    else if (underrun && cnt_reg != '1) cnt_reg <= cnt_reg + 1'b1;
  end

  assign underrun_cnt = cnt_reg;

endmodule

// File: tb/tb_disp_pix_unpack.sv
// tb_disp_pix_unpack
// ------------------
// Self-checking bench for disp_pix_unpack (PIX_W=16, RATIO=2, CNT_W=2,
// FILL_PIX=16'hF11F). A queue-based FWFT FIFO model feeds the DUT. Directed
// sections cover pattern modes, priority, alignment, underrun, saturation
// and reset. Random camera rounds push the expected pixel stream (lanes of
// every word from the sof word onward) into a scoreboard. A negedge monitor
// compares that stream whenever a pixel is consumed (href high, FIFO not
// empty).

module tb_disp_pix_unpack;

  localparam int          PIX_W = 16;
  localparam int          RATIO = 2;
  localparam int          CNT_W = 2;
  localparam logic [15:0] FILL  = 16'hF11F;
  localparam int          WW    = RATIO*PIX_W + 2;

  logic             clk;
  logic             disp_rst;
  logic             disp_bars, disp_busy, disp_cam;
  logic             fifo_empty;
  logic [WW-1:0]    fifo_rd_data;
  logic             fifo_rd_en;
  logic             href, vsync_n;
  logic [PIX_W-1:0] pat_data;
  logic             sync_en, pat_grey, pat_bars;
  logic [PIX_W-1:0] data;
  logic             underrun;
  logic [CNT_W-1:0] underrun_cnt;

  disp_pix_unpack #(
    .PIX_W(PIX_W), .RATIO(RATIO), .FILL_PIX(FILL), .CNT_W(CNT_W)
  ) dut (
    .disp_clk(clk), .disp_rst(disp_rst),
    .disp_bars(disp_bars), .disp_busy(disp_busy), .disp_cam(disp_cam),
    .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
    .href(href), .vsync_n(vsync_n), .pat_data(pat_data),
    .sync_en(sync_en), .pat_grey(pat_grey), .pat_bars(pat_bars),
    .data(data), .underrun(underrun), .underrun_cnt(underrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [WW-1:0] fq[$];     // FIFO contents, head at index 0
  logic [16:0]   sbq[$];    // expected {fifo_rd_en, pixel} per consumed pixel
  int            n_tests = 0;
  int            n_fail  = 0;
  int            nu      = 0;   // underruns provoked so far
  bit            sb_en   = 1'b0;
  logic          pop_req = 1'b0;
  logic [WW-1:0] popped;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fifo_refresh();
    fifo_empty   = (fq.size() == 0);
    fifo_rd_data = (fq.size() == 0) ? '0 : fq[0];
  endtask

  task automatic push_word(input logic sof, input logic eof, input logic [31:0] d);
    fq.push_back({eof, sof, d});
    fifo_refresh();
  endtask

  // FIFO model: pop requested in the previous cycle takes effect just after the edge.
  always @(posedge clk) begin
    #1;
    if (pop_req && fq.size() > 0) begin
      popped = fq.pop_front();
      fifo_refresh();
    end
  end

  // Monitor: records pops, checks rd-while-empty and the pixel scoreboard.
  always @(negedge clk) begin
    logic [16:0] e;
    pop_req = fifo_rd_en;
    if (fifo_empty) check("rd_when_empty", {31'd0, fifo_rd_en}, 32'd0);
    if (sb_en && href && !fifo_empty) begin
      if (sbq.size() == 0) begin
        check("sb_extra_pixel", {16'd0, data}, 32'hFFFF_FFFF);
      end else begin
        e = sbq.pop_front();
        check("sb_pix", {16'd0, data}, {16'd0, e[15:0]});
        check("sb_rden", {31'd0, fifo_rd_en}, {31'd0, e[16]});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic vs_pulse();
    step();
    vsync_n = 1'b0;
    step();
    vsync_n = 1'b1;
  endtask

  function automatic int exp_cnt();
    return (nu > 3) ? 3 : nu;
  endfunction

  // One random camera frame: junk words, a sof word, then data words.
  task automatic cam_round();
    int junk, nw, guard;
    logic [31:0] d;
    junk = $urandom_range(0, 2);
    nw   = $urandom_range(2, 6);
    for (int i = 0; i < junk; i++) push_word(1'b0, 1'b0, $urandom);
    for (int i = 0; i < nw; i++) begin
      d = $urandom;
      push_word(i == 0, (i == nw - 1) && ($urandom_range(0, 1) == 1), d);
      sbq.push_back({1'b0, d[15:0]});
      sbq.push_back({1'b1, d[31:16]});
    end
    repeat (junk + 4) step();
    sb_en = 1'b1;
    guard = 0;
    while (sbq.size() > 0 && guard < 300) begin
      href = (fq.size() > 0) && ($urandom_range(0, 3) != 0);
      step();
      guard++;
    end
    href  = 1'b0;
    sb_en = 1'b0;
    check("round_pixels_left", sbq.size(), 32'd0);
    check("round_words_left", fq.size(), 32'd0);
    sbq.delete();
    fq.delete();
    fifo_refresh();
  endtask

  // From CAM with an empty FIFO: underrun, FILL, vsync back to ALIGN.
  task automatic force_underrun();
    href = 1'b1;
    smp();
    check("ur_pulse", {31'd0, underrun}, 32'd1);
    check("ur_fill_data", {16'd0, data}, {16'd0, FILL});
    nu++;
    step();
    smp();
    check("ur_cnt", {30'd0, underrun_cnt}, exp_cnt());
    check("ur_single", {31'd0, underrun}, 32'd0);
    step();
    href = 1'b0;
    vs_pulse();
    smp();
    check("ur_realign_sync", {31'd0, sync_en}, 32'd1);
    check("ur_realign_data", {16'd0, data}, 32'd0);
  endtask

  initial begin
    int found;
    disp_rst = 1'b1;
    disp_bars = 1'b0; disp_busy = 1'b0; disp_cam = 1'b0;
    href = 1'b0; vsync_n = 1'b1; pat_data = '0;
    fifo_refresh();

    // Reset state
    repeat (2) step();
    smp();
    check("rst_sync_en", {31'd0, sync_en}, 32'd0);
    check("rst_data", {16'd0, data}, 32'd0);
    check("rst_cnt", {30'd0, underrun_cnt}, 32'd0);
    check("rst_outs", {28'd0, fifo_rd_en, underrun, pat_bars, pat_grey}, 32'd0);
    step();
    disp_rst = 1'b0;

    // Bars mode: takes effect on the 3rd clock
    step();
    disp_bars = 1'b1;
    pat_data = 16'h1357;
    step(); smp();
    check("bars_lat1", {31'd0, sync_en}, 32'd0);
    step(); smp();
    check("bars_lat2", {31'd0, sync_en}, 32'd0);
    step(); smp();
    check("bars_on_sync", {31'd0, sync_en}, 32'd1);
    check("bars_on_sel", {31'd0, pat_bars}, 32'd1);
    check("bars_data", {16'd0, data}, 32'h1357);
    step();
    pat_data = 16'hBEEF;
    disp_bars = 1'b0;
    repeat (4) step();
    smp();
    check("bars_hold", {31'd0, pat_bars}, 32'd1);
    check("bars_data2", {16'd0, data}, 32'hBEEF);
    vs_pulse(); smp();
    check("bars_exit", {30'd0, sync_en, pat_bars}, 32'd0);

    // Priority: all requests -> bars
    step();
    disp_bars = 1'b1; disp_busy = 1'b1; disp_cam = 1'b1;
    repeat (3) step();
    smp();
    check("prio_bars", {30'd0, pat_bars, pat_grey}, 32'd2);

    // Busy after bars, through IDLE
    step();
    disp_bars = 1'b0; disp_cam = 1'b0;
    repeat (4) step();
    smp();
    check("busy_wait_bars", {31'd0, pat_bars}, 32'd1);
    vs_pulse(); smp();
    check("busy_via_idle", {31'd0, sync_en}, 32'd0);
    step(); smp();
    check("busy_grey", {30'd0, pat_grey, pat_bars}, 32'd2);
    check("busy_data", {16'd0, data}, 32'hBEEF);
    step();
    disp_busy = 1'b0;
    repeat (4) step();
    vs_pulse(); smp();
    check("busy_exit", {31'd0, sync_en}, 32'd0);

    // Alignment and unpack with href held high
    step();
    push_word(1'b0, 1'b0, 32'hAAAA_BBBB);
    push_word(1'b1, 1'b0, 32'h2222_1111);
    push_word(1'b0, 1'b0, 32'h4444_3333);
    href = 1'b1;
    disp_cam = 1'b1;
    found = 0;
    for (int k = 0; k < 20; k++) begin
      smp();
      if (data === 16'h1111) begin
        found = 1;
        break;
      end
      step();
    end
    check("cam_start", found, 32'd1);
    check("align_popped", fq.size(), 32'd2);
    check("pix0_rden", {31'd0, fifo_rd_en}, 32'd0);
    step(); smp();
    check("pix1", {fifo_rd_en, 15'd0, data}, {1'b1, 15'd0, 16'h2222});
    step(); smp();
    check("pix2", {fifo_rd_en, 15'd0, data}, {1'b0, 15'd0, 16'h3333});
    step(); smp();
    check("pix3", {fifo_rd_en, 15'd0, data}, {1'b1, 15'd0, 16'h4444});

    // Underrun following the last word
    step(); smp();
    check("ur0_pulse", {31'd0, underrun}, 32'd1);
    check("ur0_data", {16'd0, data}, {16'd0, FILL});
    check("ur0_cnt_before", {30'd0, underrun_cnt}, 32'd0);
    nu = 1;
    step(); smp();
    check("ur0_single", {31'd0, underrun}, 32'd0);
    check("ur0_cnt", {30'd0, underrun_cnt}, 32'd1);
    check("fill_data", {16'd0, data}, {16'd0, FILL});
    step(); smp();
    check("fill_no_recount", {30'd0, underrun_cnt}, 32'd1);
    check("fill_data2", {16'd0, data}, {16'd0, FILL});
    step();
    href = 1'b0;
    vs_pulse(); smp();
    check("fill_to_align", {15'd0, sync_en, data}, 32'h0001_0000);

    // Random frames, each ending in a forced underrun (count saturates at 3)
    for (int r = 0; r < 4; r++) begin
      cam_round();
      force_underrun();
    end
    check("cnt_saturated", {30'd0, underrun_cnt}, 32'd3);

    // Exit coinciding with an underrun: no pulse, no count
    cam_round();
    disp_cam = 1'b0;
    repeat (3) step();
    smp();
    check("cam_hold", {31'd0, sync_en}, 32'd1);
    step();
    href = 1'b1;
    vsync_n = 1'b0;
    smp();
    check("exit_no_pulse", {31'd0, underrun}, 32'd0);
    step();
    vsync_n = 1'b1;
    href = 1'b0;
    smp();
    check("exit_idle", {31'd0, sync_en}, 32'd0);
    check("exit_cnt", {30'd0, underrun_cnt}, 32'd3);

    // Reset mid-CAM
    step();
    disp_cam = 1'b1;
    push_word(1'b1, 1'b0, 32'h5678_1234);
    repeat (6) step();
    smp();
    check("resume_data", {15'd0, sync_en, data}, 32'h0001_1234);
    step();
    disp_rst = 1'b1;
    #1;
    check("midrst_cnt", {30'd0, underrun_cnt}, 32'd0);
    check("midrst_data", {16'd0, data}, 32'd0);
    check("midrst_outs", {27'd0, sync_en, fifo_rd_en, underrun, pat_bars, pat_grey}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
